// File: rtl/relax_osc_pkg.sv
// Shared state type, default widths and counter helpers for the relaxation-oscillator frequency meter.
// Build option RELAX_OSC_SAT_EN: when defined the edge counter saturates at its maximum instead of wrapping.
package relax_osc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } meter_state_t;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_GATE_W      = 20;
    localparam int DEF_SYNC_STAGES = 2;

`ifdef RELAX_OSC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Channel-select width; a single-channel meter still carries a 1-bit select.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // True when an increment from the maximum must hold the count instead of wrapping to zero.
    function automatic logic hold_at_max(input logic at_max);
        return at_max & SAT_EN;
    endfunction

endpackage

// File: rtl/relax_osc_freq_meter_if.sv
// Measurement control/result bundle between a controller (master) and the frequency meter (slave).
interface relax_osc_freq_meter_if #(
    parameter int NUM_CH = relax_osc_pkg::DEF_NUM_CH,
    parameter int CNT_W  = relax_osc_pkg::DEF_CNT_W,
    parameter int GATE_W = relax_osc_pkg::DEF_GATE_W
);
    import relax_osc_pkg::*;

    localparam int SEL_W = sel_width(NUM_CH);

    logic [SEL_W-1:0]  ch_sel;
    logic [GATE_W-1:0] gate_len;
    logic              cont;
    logic              start;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  result;
    logic              overflow;

    modport master (
        output ch_sel, gate_len, cont, start,
        input  busy, done, result, overflow
    );

    modport slave (
        input  ch_sel, gate_len, cont, start,
        output busy, done, result, overflow
    );

endinterface

// File: rtl/relax_osc_sync_edge.sv
// Multi-flop synchroniser for one asynchronous oscillator input followed by a rising-edge detector.
module relax_osc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain_reg;
    logic                   sync_d_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg  <= '0;
            sync_d_reg <= 1'b0;
        end else begin
            chain_reg  <= {chain_reg[SYNC_STAGES-2:0], d};
            sync_d_reg <= chain_reg[SYNC_STAGES-1];
        end
    end

    // A rise needs one low sample followed by one high sample, capping countable input at clk/2.
    assign rise = chain_reg[SYNC_STAGES-1] & ~sync_d_reg;

endmodule

// File: rtl/relax_osc_freq_meter.sv
// Gated rising-edge counter for one of NUM_CH synchronised oscillator inputs, single-shot or continuous.
module relax_osc_freq_meter
    import relax_osc_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GATE_W      = DEF_GATE_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [NUM_CH-1:0]     osc_in,
    relax_osc_freq_meter_if.slave bus
);

    localparam int SEL_W    = sel_width(NUM_CH);
    localparam int SEL_SPAN = 1 << SEL_W;
    localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

    logic [SEL_SPAN-1:0] rise_vec;

    // Rise vector is padded to the full select span so any captured select indexes a defined bit.
    generate
        for (genvar gi = 0; gi < SEL_SPAN; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_sync
                relax_osc_sync_edge #(
                    .SYNC_STAGES(SYNC_STAGES)
                ) u_sync (
                    .clk  (clk),
                    .rst  (rst),
                    .d    (osc_in[gi]),
                    .rise (rise_vec[gi])
                );
            end else begin : g_pad
                assign rise_vec[gi] = 1'b0;
            end
        end
    endgenerate

    meter_state_t      state_reg;
    logic [SEL_W-1:0]  ch_reg;
    logic [GATE_W-1:0] gate_len_reg;
    logic [GATE_W-1:0] gate_cnt_reg;
    logic [CNT_W-1:0]  edge_cnt_reg;
    logic              ovf_reg;
    logic [CNT_W-1:0]  result_reg;
    logic              overflow_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [SEL_W-1:0]  ch_sel_eff;
    logic [GATE_W-1:0] gate_len_eff;
    logic              ch_rise;
    logic              at_max;
    logic [CNT_W-1:0]  edge_cnt_next;
    logic              ovf_next;

    assign ch_sel_eff   = ({1'b0, bus.ch_sel} < NUM_CH_L) ? bus.ch_sel : '0;
    assign gate_len_eff = (bus.gate_len == '0) ? GATE_W'(1) : bus.gate_len;
    assign ch_rise      = rise_vec[ch_reg];
    assign at_max       = &edge_cnt_reg;

    always_comb begin
        edge_cnt_next = edge_cnt_reg;
        ovf_next      = ovf_reg;
        if (ch_rise) begin
            if (!hold_at_max(at_max)) begin
                edge_cnt_next = edge_cnt_reg + CNT_W'(1);
            end
            if (at_max) begin
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ch_reg       <= '0;
            gate_len_reg <= '0;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            ovf_reg      <= 1'b0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!ena) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start) begin
                            ch_reg       <= ch_sel_eff;
                            gate_len_reg <= gate_len_eff;
                            gate_cnt_reg <= gate_len_eff;
                            edge_cnt_reg <= '0;
                            ovf_reg      <= 1'b0;
                            busy_reg     <= 1'b1;
                            state_reg    <= GATE;
                        end
                    end
                    GATE: begin
                        edge_cnt_reg <= edge_cnt_next;
                        ovf_reg      <= ovf_next;
                        gate_cnt_reg <= gate_cnt_reg - GATE_W'(1);
                        // Result is captured on entry to LATCH so it is already valid while done is high.
                        if (gate_cnt_reg == GATE_W'(1)) begin
                            result_reg   <= edge_cnt_next;
                            overflow_reg <= ovf_next;
                            done_reg     <= 1'b1;
                            state_reg    <= LATCH;
                        end
                    end
                    LATCH: begin
                        if (bus.cont) begin
                            gate_cnt_reg <= gate_len_reg;
                            edge_cnt_reg <= '0;
                            ovf_reg      <= 1'b0;
                            state_reg    <= GATE;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                    default: begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.result   = result_reg;
    assign bus.overflow = overflow_reg;

endmodule
